matrix_mem_responder: RTL and testbench

MATRIX_MEM_RESPONDER -- requirements
Module: matrix_mem_responder

---
 rtl/matrix_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_matrix_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mem_responder.sv
// -----------------------------------------------------------------------------
// matrix_mem_responder
//
// Memory-side responder for a matrix engine. An initiator issues one request at
// a time on mem_operation/addr_i/data_i. The block accepts the request in IDLE,
// waits LATENCY cycles, and then pulses mem_opdone for one cycle. A host port
// can preload or inspect the local word storage at any time.
//
// Handshake: a request is accepted on any rising edge that samples
// mem_operation != 2'b00 while the block is IDLE. The initiator must keep
// mem_operation non-zero until it samples mem_opdone. Sampling 2'b00 while
// waiting aborts the request with no side effect. A request still present in
// the IDLE cycle after mem_opdone is a new request.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous, active-low
//   mem_operation  : 01 read, 11 write, 00 none, 10 illegal
//   addr_i         : request word address
//   data_i         : request write data
//   data_o         : read data, valid in the mem_opdone cycle of a read
//   mem_opdone     : one-cycle completion pulse per accepted request
//   host_we        : host write strobe
//   host_addr      : host word address
//   host_wdata     : host write data
//   host_rdata     : registered read of host_addr (read-before-write)
//   busy           : request in flight (WAIT or DONE)
//   err            : sticky error flag, cleared only by reset
//   host_collision : one-cycle pulse when a host write lost to the protocol
//   dbg_state_o    : current FSM state, for observation
// -----------------------------------------------------------------------------
`ifndef TYPE_BW
`define TYPE_BW 32
`endif

module matrix_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mem_operation,
  input  logic [31:0]         addr_i,
  input  logic [`TYPE_BW-1:0] data_i,
  output logic [`TYPE_BW-1:0] data_o,
  output logic                mem_opdone,
  input  logic                host_we,
  input  logic [31:0]         host_addr,
  input  logic [`TYPE_BW-1:0] host_wdata,
  output logic [`TYPE_BW-1:0] host_rdata,
  output logic                busy,
  output logic                err,
  output logic                host_collision,
  output logic [1:0]          dbg_state_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_NONE    = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_ILLEGAL = 2'b10;
  localparam logic [1:0] OP_WRITE   = 2'b11;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [31:0]         addr_q, addr_d;
  logic [`TYPE_BW-1:0] wdata_q, wdata_d;
  logic [`TYPE_BW-1:0] data_o_q;
  logic [`TYPE_BW-1:0] host_rdata_q;
  logic                err_q;
  logic                host_coll_q;

  logic [`TYPE_BW-1:0] mem_q [DEPTH];

  logic enter_done;
  logic commit_in_range;
  logic host_in_range;
  logic proto_we;
  logic proto_rd;
  logic commit_err;
  logic host_collide;
  logic host_do_write;

  // Next-state logic. The *_d request fields always name the request that is
  // committing this edge: on acceptance they come straight from the inputs
  // (needed when LATENCY is 1), otherwise they hold the latched values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_operation != OP_NONE) begin
          op_d    = mem_operation;
          addr_d  = addr_i;
          wdata_d = data_i;
          if (LATENCY == 1) begin
            state_d    = S_DONE;
            cnt_d      = 4'd0;
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        // A withdrawn request wins over completion, even on the last wait cycle.
        if (mem_operation == OP_NONE) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d    = S_DONE;
          cnt_d      = 4'd0;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign commit_in_range = (addr_d < 32'(DEPTH));
  assign host_in_range   = (host_addr < 32'(DEPTH));
  assign proto_we        = enter_done && (op_d == OP_WRITE) && commit_in_range;
  assign proto_rd        = enter_done && (op_d == OP_READ);
  assign commit_err      = enter_done && ((op_d == OP_ILLEGAL) || !commit_in_range);
  // Both addresses are in range here, so full-width equality is the same word.
  assign host_collide    = host_we && host_in_range && proto_we && (host_addr == addr_d);
  assign host_do_write   = host_we && host_in_range && !host_collide;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      op_q         <= OP_NONE;
      addr_q       <= 32'd0;
      wdata_q      <= '0;
      data_o_q     <= '0;
      host_rdata_q <= '0;
      err_q        <= 1'b0;
      host_coll_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      host_coll_q <= host_collide;
      err_q       <= err_q | commit_err | (host_we && !host_in_range);
      if (proto_rd) begin
        data_o_q <= commit_in_range ? mem_q[addr_d[AW-1:0]] : '0;
      end
      // Non-blocking update of mem_q gives read-before-write on the same edge.
      host_rdata_q <= host_in_range ? mem_q[host_addr[AW-1:0]] : '0;
    end
  end

  // Storage has no reset; writes are suppressed while reset is asserted so a
  // cancelled request never lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (proto_we) begin
        mem_q[addr_d[AW-1:0]] <= wdata_d;
      end
      if (host_do_write) begin
        mem_q[host_addr[AW-1:0]] <= host_wdata;
      end
    end
  end

  assign data_o         = data_o_q;
  assign mem_opdone     = (state_q == S_DONE);
  assign host_rdata     = host_rdata_q;
  assign busy           = (state_q == S_WAIT) || (state_q == S_DONE);
  assign err            = err_q;
  assign host_collision = host_coll_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_matrix_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_matrix_mem_responder
//
// Directed and randomized checks of matrix_mem_responder against a
// transaction-level model: a word array for storage plus expected data_o and
// err values, updated once per completed request or host write.
// -----------------------------------------------------------------------------
`ifndef TYPE_BW
`define TYPE_BW 32
`endif

module tb_matrix_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int W     = `TYPE_BW;

  logic          clk;
  logic          reset;
  logic [1:0]    mem_operation;
  logic [31:0]   addr_i;
  logic [W-1:0]  data_i;
  logic [W-1:0]  data_o;
  logic          mem_opdone;
  logic          host_we;
  logic [31:0]   host_addr;
  logic [W-1:0]  host_wdata;
  logic [W-1:0]  host_rdata;
  logic          busy;
  logic          err;
  logic          host_collision;
  logic [1:0]    dbg_state;

  matrix_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_operation (mem_operation),
    .addr_i        (addr_i),
    .data_i        (data_i),
    .data_o        (data_o),
    .mem_opdone    (mem_opdone),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .busy          (busy),
    .err           (err),
    .host_collision(host_collision),
    .dbg_state_o   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [W-1:0] mm [DEPTH];
  logic [W-1:0] exp_dout;
  logic         exp_err;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    mem_operation = 2'b00;
    host_we       = 1'b0;
    step();
    check({tag, "_opdone_low"}, W'(mem_opdone), W'(1'b0));
  endtask

  task automatic host_write(input logic [31:0] a, input logic [W-1:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    step();
    host_we = 1'b0;
    if (a < DEPTH) mm[a] = d;
    else exp_err = 1'b1;
  endtask

  task automatic host_read(input logic [31:0] a, input string tag);
    host_we   = 1'b0;
    host_addr = a;
    step();
    check(tag, host_rdata, (a < DEPTH) ? mm[a] : '0);
  endtask

  // Issue one request and wait for its completion. exp_n is the number of
  // edges from the call to the mem_opdone cycle: LAT when called from IDLE,
  // LAT+1 when called in the previous request's mem_opdone cycle.
  task automatic do_req(input logic [1:0] op, input logic [31:0] a,
                        input logic [W-1:0] d, input int exp_n, input string tag);
    int  n;
    bit  seen;
    bit  in_r;
    in_r = (a < DEPTH);
    case (op)
      2'b01: begin
        exp_dout = in_r ? mm[a] : '0;
        if (!in_r) exp_err = 1'b1;
      end
      2'b11: begin
        if (in_r) mm[a] = d;
        else exp_err = 1'b1;
      end
      default: exp_err = 1'b1;
    endcase
    mem_operation = op;
    addr_i        = a;
    data_i        = d;
    n    = 0;
    seen = 0;
    while (!seen && n < exp_n + 6) begin
      step();
      n++;
      // After acceptance, scramble address/data; the latched request must hold.
      if (n == exp_n - LAT + 1) begin
        addr_i = $urandom;
        data_i = $urandom;
      end
      if (mem_opdone) seen = 1;
    end
    check({tag, "_latency"}, W'(n), W'(exp_n));
    check({tag, "_data_o"}, data_o, exp_dout);
    check({tag, "_err"}, W'(err), W'(exp_err));
    check({tag, "_busy"}, W'(busy), W'(1'b1));
  endtask

  logic [W-1:0] old_val;
  logic [31:0]  ra;
  logic [1:0]   rop;

  initial begin
    reset         = 1'b0;
    mem_operation = 2'b00;
    addr_i        = '0;
    data_i        = '0;
    host_we       = 1'b0;
    host_addr     = '0;
    host_wdata    = '0;
    exp_dout      = '0;
    exp_err       = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_data_o", data_o, '0);
    check("rst_opdone", W'(mem_opdone), '0);
    check("rst_host_rdata", host_rdata, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_err", W'(err), '0);
    check("rst_coll", W'(host_collision), '0);
    reset = 1'b1;
    step();

    // Preload all storage through the host port
    for (int i = 0; i < DEPTH; i++) host_write(32'(i), W'($urandom));
    host_write(32'd1, 3);
    host_write(32'd2, 2);
    host_write(32'd3, 3);
    host_write(32'd4, 2);
    host_read(32'd0, "hrd_0");
    host_read(32'd3, "hrd_3");
    host_read(32'(DEPTH - 1), "hrd_top");
    host_read(32'(DEPTH), "hrd_oor");

    // Back-to-back reads with held op, one completion every LAT+1 cycles
    do_req(2'b01, 32'd1, '0, LAT, "b2b_1");
    check("b2b_1_val", data_o, 3);
    do_req(2'b01, 32'd2, '0, LAT + 1, "b2b_2");
    check("b2b_2_val", data_o, 2);
    do_req(2'b01, 32'd3, '0, LAT + 1, "b2b_3");
    check("b2b_3_val", data_o, 3);
    do_req(2'b01, 32'd4, '0, LAT + 1, "b2b_4");
    check("b2b_4_val", data_o, 2);
    idle("b2b_end");
    check("b2b_busy_low", W'(busy), '0);

    // Write then read back
    do_req(2'b11, 32'h20, 32'hFFFF_FFF9, LAT, "wr20");
    idle("wr20");
    do_req(2'b01, 32'h20, '0, LAT, "rd20");
    check("rd20_val", data_o, 32'hFFFF_FFF9);
    check("rd20_err", W'(err), '0);
    idle("rd20");

    // Write aborted in WAIT: no completion, no memory effect
    old_val       = mm[12];
    mem_operation = 2'b11;
    addr_i        = 32'd12;
    data_i        = ~old_val;
    step();
    check("abort_busy", W'(busy), W'(1'b1));
    mem_operation = 2'b00;
    step();
    check("abort_opdone", W'(mem_opdone), '0);
    check("abort_idle", W'(busy), '0);
    step();
    check("abort_opdone2", W'(mem_opdone), '0);
    do_req(2'b01, 32'd12, '0, LAT, "abort_rd");
    check("abort_rd_old", data_o, old_val);
    check("abort_err", W'(err), '0);
    idle("abort_rd");

    // Host write and protocol write to addr 7 on the same edge
    old_val       = mm[7];
    mem_operation = 2'b11;
    addr_i        = 32'd7;
    data_i        = 32'hAA;
    step();
    host_we    = 1'b1;
    host_addr  = 32'd7;
    host_wdata = 32'h55;
    step();
    check("coll_opdone", W'(mem_opdone), W'(1'b1));
    check("coll_pulse", W'(host_collision), W'(1'b1));
    check("coll_rbw", host_rdata, old_val);
    host_we       = 1'b0;
    mem_operation = 2'b00;
    step();
    check("coll_pulse_end", W'(host_collision), '0);
    mm[7] = 32'hAA;
    host_read(32'd7, "coll_hrd");
    do_req(2'b01, 32'd7, '0, LAT, "coll_rd");
    idle("coll_rd");

    // Randomized mix of requests and host traffic
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0:       ra = 32'(DEPTH) + $urandom_range(0, 1000);
        1:       ra = 32'(DEPTH - 1);
        default: ra = $urandom_range(0, 15);
      endcase
      case ($urandom_range(0, 3))
        0: host_write(ra, W'($urandom));
        1: host_read(ra, "rnd_hrd");
        default: begin
          rop = ($urandom_range(0, 7) == 0) ? 2'b10 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
          do_req(rop, ra, W'($urandom), LAT, "rnd_req");
          idle("rnd_req");
        end
      endcase
    end

    // Out-of-range read: zero data, pulse, sticky err
    do_req(2'b01, 32'(DEPTH), '0, LAT, "oor_rd");
    check("oor_rd_zero", data_o, '0);
    check("oor_rd_err", W'(err), W'(1'b1));
    idle("oor_rd");
    repeat (3) step();
    check("oor_err_sticky", W'(err), W'(1'b1));

    // Reset during WAIT of a write to addr 9
    old_val       = mm[9];
    mem_operation = 2'b11;
    addr_i        = 32'd9;
    data_i        = ~old_val;
    step();
    check("rstw_busy", W'(busy), W'(1'b1));
    reset = 1'b0;
    step();
    check("rstw_opdone", W'(mem_opdone), '0);
    check("rstw_data_o", data_o, '0);
    check("rstw_host_rdata", host_rdata, '0);
    check("rstw_busy_low", W'(busy), '0);
    check("rstw_err", W'(err), '0);
    check("rstw_coll", W'(host_collision), '0);
    reset         = 1'b1;
    mem_operation = 2'b00;
    exp_dout      = '0;
    exp_err       = 1'b0;
    step();
    check("rstw_opdone2", W'(mem_opdone), '0);
    do_req(2'b01, 32'd9, '0, LAT, "rstw_rd");
    check("rstw_rd_old", data_o, old_val);
    idle("rstw_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
